// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline stage register with optional skid buffer
//
// Purpose: carries an opaque data bundle and a control bundle between two CPU
// pipeline stages. When no valid entry is held, the control bundle is squashed
// to CTRL_BUBBLE. SKID=1 adds a second entry so that in_ready is a register
// output. SKID=0 keeps a single entry with a combinational in_ready.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   flush                 squash all held and incoming entries
//   in_valid/in_ready     upstream handshake; in_data/in_ctrl are the entry
//   out_valid/out_ready   downstream handshake; out_data/out_ctrl are the head entry
//   occupancy             number of entries held (0..2)

module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 5,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                SKID        = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HEAD  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              ready_q;
    logic              accept;
    logic              release_head;

    // ready_q resets to 1; gating with reset_n holds in_ready low during
    // reset and lets it rise in the very first cycle after release.
    always_comb begin
        if (SKID != 0) begin
            in_ready = reset_n & ready_q;
        end else begin
            in_ready = reset_n & ((state == ST_EMPTY) | out_ready);
        end
    end

    assign out_valid    = (state != ST_EMPTY);
    assign accept       = in_valid & in_ready;
    assign release_head = out_valid & out_ready;
    assign out_data     = head_data;
    // Downstream must never see write enables without a valid entry.
    assign out_ctrl     = out_valid ? head_ctrl : CTRL_BUBBLE;
    assign occupancy    = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            head_data <= '0;
            head_ctrl <= CTRL_BUBBLE;
            skid_data <= '0;
            skid_ctrl <= CTRL_BUBBLE;
            ready_q   <= 1'b1;
        end else if (flush) begin
            // Entry offered in this cycle is dropped; data holds last value.
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_data <= in_data;
                        head_ctrl <= in_ctrl;
                        state     <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (accept && release_head) begin
                        head_data <= in_data;
                        head_ctrl <= in_ctrl;
                    end else if (accept) begin
                        // Only reachable with SKID=1: park the entry in the skid slot.
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        state     <= ST_FULL;
                        ready_q   <= 1'b0;
                    end else if (release_head) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (release_head) begin
                        head_data <= skid_data;
                        head_ctrl <= skid_ctrl;
                        state     <= ST_HEAD;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_ctrl;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [4:0]  a_out_ctrl;
    logic [1:0]  a_occ;

    logic        z_in_ready, z_out_valid;
    logic [31:0] z_out_data;
    logic [4:0]  z_out_ctrl;
    logic [1:0]  z_occ;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [4:0]  b_out_ctrl;
    logic [1:0]  b_occ;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .CTRL_BUBBLE(5'b00000), .SKID(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .CTRL_BUBBLE(5'b00000), .SKID(0)) u_dut_noskid (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
        .out_ctrl(z_out_ctrl), .occupancy(z_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .CTRL_BUBBLE(5'b00001), .SKID(1)) u_dut_bubble (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 5'b11111; out_ready = 1'b1;
        tick(); tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        checks++; if (a_out_ctrl !== 5'b0) begin errors++; $display("FAIL reset_out_ctrl got %b want 00000", a_out_ctrl); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", a_in_ready); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", a_occ); end
        checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
        reset_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", a_in_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_d;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d = 32'h100 + 32'(4 * i);
            in_valid = 1'b1; in_data = exp_d; in_ctrl = 5'(i + 1);
            tick();
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, a_out_valid); end
            checks++; if (a_out_data !== exp_d) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, a_out_data, exp_d); end
            checks++; if (a_out_ctrl !== 5'(i + 1)) begin errors++; $display("FAIL stream_ctrl[%0d] got %b want %b", i, a_out_ctrl, 5'(i + 1)); end
            checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", i, a_occ); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b want 0", a_out_valid); end
        checks++; if (a_out_ctrl !== 5'b0) begin errors++; $display("FAIL stream_drain_ctrl got %b want 00000", a_out_ctrl); end
    endtask

    task automatic test_stall_fill();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA0; in_ctrl = 5'd1;
        tick();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready1 got %b want 1", a_in_ready); end
        checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL fill_occ1 got %0d want 1", a_occ); end
        in_data = 32'hA4; in_ctrl = 5'd2;
        tick();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready2 got %b want 0", a_in_ready); end
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL fill_occ2 got %0d want 2", a_occ); end
        in_data = 32'hA8; in_ctrl = 5'd3;
        tick();
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL fill_hold_occ got %0d want 2", a_occ); end
        checks++; if (a_out_data !== 32'hA0) begin errors++; $display("FAIL fill_head got %h want a0", a_out_data); end
        checks++; if (a_out_ctrl !== 5'd1) begin errors++; $display("FAIL fill_head_ctrl got %b want 00001", a_out_ctrl); end
        out_ready = 1'b1;
        tick();
        checks++; if (a_out_data !== 32'hA4) begin errors++; $display("FAIL drain_a4 got %h want a4", a_out_data); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", a_in_ready); end
        checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL drain_occ got %0d want 1", a_occ); end
        tick();
        checks++; if (a_out_data !== 32'hA8) begin errors++; $display("FAIL drain_a8 got %h want a8", a_out_data); end
        checks++; if (a_out_ctrl !== 5'd3) begin errors++; $display("FAIL drain_a8_ctrl got %b want 00011", a_out_ctrl); end
        in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", a_out_valid); end
    endtask

    task automatic test_flush_full();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 5'b10110;
        tick();
        in_data = 32'h22; in_ctrl = 5'b00011;
        tick();
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", a_occ); end
        checks++; if (a_out_ctrl !== 5'b10110) begin errors++; $display("FAIL flush_pre_ctrl got %b want 10110", a_out_ctrl); end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; in_ctrl = 5'b11111;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
        checks++; if (a_out_ctrl !== 5'b0) begin errors++; $display("FAIL flush_ctrl got %b want 00000", a_out_ctrl); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", a_occ); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", a_in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped[%0d] valid %b data %h want invalid", i, a_out_valid, a_out_data); end
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 5'b00111;
        tick();
        in_valid = 1'b0; reset_n = 1'b0; flush = 1'b1;
        tick();
        reset_n = 1'b1; flush = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstflush_valid got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL rstflush_data got %h want 0", a_out_data); end
        checks++; if (a_out_ctrl !== 5'b0) begin errors++; $display("FAIL rstflush_ctrl got %b want 00000", a_out_ctrl); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rstflush_ready got %b want 1", a_in_ready); end
        in_valid = 1'b1; in_data = 32'h1; tick();
        in_data = 32'h2; tick();
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL midstall_pre_occ got %0d want 2", a_occ); end
        in_valid = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL midstall_occ got %0d want 0", a_occ); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL midstall_ready got %b want 1", a_in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midstall_lost got %b want 0", a_out_valid); end
    endtask

    task automatic test_noskid_passthrough();
        logic        rdy_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] din_seq [4] = '{32'd1, 32'd2, 32'd2, 32'd3};
        logic        exp_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_out [4] = '{32'd1, 32'd1, 32'd2, 32'd3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = din_seq[i]; out_ready = rdy_seq[i];
            #1;
            checks++; if (z_in_ready !== exp_rdy[i]) begin errors++; $display("FAIL noskid_ready[%0d] got %b want %b", i, z_in_ready, exp_rdy[i]); end
            tick();
            checks++; if (z_out_data !== exp_out[i]) begin errors++; $display("FAIL noskid_data[%0d] got %h want %h", i, z_out_data, exp_out[i]); end
            checks++; if (z_occ !== 2'd1) begin errors++; $display("FAIL noskid_occ[%0d] got %0d want 1", i, z_occ); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (z_out_valid !== 1'b0) begin errors++; $display("FAIL noskid_empty got %b want 0", z_out_valid); end
        checks++; if (z_occ !== 2'd0) begin errors++; $display("FAIL noskid_empty_occ got %0d want 0", z_occ); end
    endtask

    task automatic test_bubble_ctrl();
        do_reset();
        #1;
        checks++; if (b_out_ctrl !== 5'b00001) begin errors++; $display("FAIL bubble_after_reset got %b want 00001", b_out_ctrl); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b_out_ctrl !== 5'b00001) begin errors++; $display("FAIL bubble_idle[%0d] got %b want 00001", i, b_out_ctrl); end
        end
        in_valid = 1'b1; in_data = 32'h9; in_ctrl = 5'b11000;
        tick();
        in_valid = 1'b0;
        checks++; if (b_out_ctrl !== 5'b11000) begin errors++; $display("FAIL bubble_entry got %b want 11000", b_out_ctrl); end
        out_ready = 1'b1;
        tick();
        checks++; if (b_out_ctrl !== 5'b00001) begin errors++; $display("FAIL bubble_after_release got %b want 00001", b_out_ctrl); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b want 0", b_out_valid); end
        tick();
        checks++; if (b_out_ctrl !== 5'b00001) begin errors++; $display("FAIL bubble_stay got %b want 00001", b_out_ctrl); end
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush_full();
        test_reset_priority();
        test_noskid_passthrough();
        test_bubble_ctrl();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
